// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC constants: opcodes, immediate modifiers, error codes and
// encoder FSM state encodings, plus small decode helpers.
package simplerisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [1:0] MOD_SEXT    = 2'b00;
  localparam logic [1:0] MOD_ZEXT    = 2'b01;
  localparam logic [1:0] MOD_HIGH    = 2'b10;
  localparam logic [1:0] MOD_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_IMM    = 2'b01;
  localparam logic [1:0] ERR_BRANCH = 2'b10;
  localparam logic [1:0] ERR_MOD    = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ENC  = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_B) || (op == OP_BEQ) || (op == OP_BGT) || (op == OP_CALL);
  endfunction

  function automatic logic is_bare(input logic [4:0] op);
    return (op == OP_NOP) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/encode_word.sv
// Combinational packer: builds the 32-bit instruction word from its fields and
// flags immediate-range, branch-range and illegal-modifier errors.
module encode_word
  import simplerisc_pkg::*;
(
  input  logic [4:0]  op,
  input  logic        ibit,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [1:0]  modifier,
  input  logic [31:0] imm_value,
  input  logic [31:0] target,
  input  logic [31:0] pc,
  output logic [31:0] word,
  output logic        err,
  output logic [1:0]  err_code
);

  logic [31:0] offset;

  always_comb begin
    word      = '0;
    err       = 1'b0;
    err_code  = ERR_NONE;
    offset    = target - pc;
    word[31:27] = op;
    if (is_branch(op)) begin
      // Offset is in words, unscaled; it must sign-extend from bit 26.
      word[26:0] = offset[26:0];
      if (!((offset[31:26] == 6'h00) || (offset[31:26] == 6'h3f))) begin
        err      = 1'b1;
        err_code = ERR_BRANCH;
      end
    end else if (!is_bare(op)) begin
      word[25:22] = rd;
      word[21:18] = rs1;
      if (ibit) begin
        word[26]    = 1'b1;
        word[17:16] = modifier;
        case (modifier)
          MOD_SEXT: begin
            word[15:0] = imm_value[15:0];
            if (!((imm_value[31:15] == 17'h00000) || (imm_value[31:15] == 17'h1ffff))) begin
              err      = 1'b1;
              err_code = ERR_IMM;
            end
          end
          MOD_ZEXT: begin
            word[15:0] = imm_value[15:0];
            if (imm_value[31:16] != 16'h0000) begin
              err      = 1'b1;
              err_code = ERR_IMM;
            end
          end
          MOD_HIGH: begin
            word[15:0] = imm_value[31:16];
            if (imm_value[15:0] != 16'h0000) begin
              err      = 1'b1;
              err_code = ERR_IMM;
            end
          end
          default: begin
            err      = 1'b1;
            err_code = ERR_MOD;
          end
        endcase
      end else begin
        word[17:14] = rs2;
      end
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Accepts instruction fields, encodes them and writes the word to instruction
// memory at a self-incrementing address. FSM: IDLE -> ENC -> WR -> IDLE.
module instruction_encoder
  import simplerisc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  op,
  input  logic        ibit,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [1:0]  modifier,
  input  logic [31:0] imm_value,
  input  logic [31:0] target,
  input  logic        pc_load,
  input  logic [31:0] pc_value,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [15:0] words_written,
  output logic [1:0]  state_dbg
);

  // Handshake: a field set transfers on a rising edge where in_valid and
  // in_ready are both high; a memory write completes where mem_we and
  // mem_ready are both high, and mem_we/addr/wdata hold until then.
  logic [1:0]  state;
  logic [31:0] pc;
  logic [4:0]  op_q;
  logic        ibit_q;
  logic [3:0]  rd_q, rs1_q, rs2_q;
  logic [1:0]  modifier_q;
  logic [31:0] imm_q, target_q;
  logic [31:0] enc_word;
  logic        enc_err;
  logic [1:0]  enc_code;

  assign in_ready  = (state == ST_IDLE) && !pc_load && !rst;
  assign state_dbg = state;

  encode_word u_encode_word (
    .op        (op_q),
    .ibit      (ibit_q),
    .rd        (rd_q),
    .rs1       (rs1_q),
    .rs2       (rs2_q),
    .modifier  (modifier_q),
    .imm_value (imm_q),
    .target    (target_q),
    .pc        (pc),
    .word      (enc_word),
    .err       (enc_err),
    .err_code  (enc_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pc            <= BASE_ADDR;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      err_valid     <= 1'b0;
      err_code      <= ERR_NONE;
      words_written <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pc_load) begin
            pc <= pc_value;
          end else if (in_valid) begin
            op_q       <= op;
            ibit_q     <= ibit;
            rd_q       <= rd;
            rs1_q      <= rs1;
            rs2_q      <= rs2;
            modifier_q <= modifier;
            imm_q      <= imm_value;
            target_q   <= target;
            state      <= ST_ENC;
          end
        end
        ST_ENC: begin
          if (enc_err) begin
            err_valid <= 1'b1;
            err_code  <= enc_code;
            state     <= ST_IDLE;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= pc;
            mem_wdata <= enc_word;
            state     <= ST_WR;
          end
        end
        ST_WR: begin
          if (mem_ready) begin
            mem_we        <= 1'b0;
            pc            <= pc + 32'd1;
            words_written <= words_written + 16'd1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed cases plus randomized
// instructions checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_instruction_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic        ibit;
  logic [3:0]  rd, rs1, rs2;
  logic [1:0]  modifier;
  logic [31:0] imm_value, target;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] words_written;
  logic [1:0]  state_dbg;

  instruction_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ibit(ibit), .rd(rd), .rs1(rs1), .rs2(rs2), .modifier(modifier),
    .imm_value(imm_value), .target(target), .pc_load(pc_load), .pc_value(pc_value),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .err_valid(err_valid), .err_code(err_code), .words_written(words_written),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] m_pc;
  logic [15:0] m_words;
  logic [1:0]  m_last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: word layout and ranges derived with plain arithmetic.
  task automatic model_encode(input logic [4:0] o, input logic ib, input logic [3:0] d,
                              input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] md,
                              input logic [31:0] imm, input logic [31:0] tgt, input logic [31:0] pc,
                              output logic [31:0] w, output logic [1:0] ec);
    logic [31:0] off;
    longint      sv;
    longint      simm;
    int          oi;
    oi = int'(o);
    w  = 32'(oi) * 32'h0800_0000;
    ec = 2'd0;
    if (oi >= 16 && oi <= 19) begin
      off = tgt - pc;
      sv  = longint'($signed(off));
      if (sv < -67108864 || sv > 67108863) ec = 2'd2;
      w = w + (off % 32'h0800_0000);
    end else if (oi != 13 && oi != 20) begin
      w = w + 32'(d) * 32'h0040_0000 + 32'(s1) * 32'h0004_0000;
      if (ib == 1'b0) begin
        w = w + 32'(s2) * 32'h0000_4000;
      end else begin
        w = w + 32'h0400_0000 + 32'(md) * 32'h0001_0000;
        simm = longint'($signed(imm));
        case (md)
          2'd0: begin
            if (simm < -32768 || simm > 32767) ec = 2'd1;
            w = w + (imm % 32'h0001_0000);
          end
          2'd1: begin
            if (imm >= 32'h0001_0000) ec = 2'd1;
            w = w + (imm % 32'h0001_0000);
          end
          2'd2: begin
            if ((imm % 32'h0001_0000) != 0) ec = 2'd1;
            w = w + (imm / 32'h0001_0000);
          end
          default: ec = 2'd3;
        endcase
      end
    end
  endtask

  // Driver tasks (inputs change on the falling edge, outputs sampled there too)
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_words", {16'd0, words_written}, 32'd0);
    rst = 1'b0;
    m_pc = BASE;
    m_words = 16'd0;
    m_last_err = 2'd0;
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic load_pc(input logic [31:0] v);
    @(negedge clk);
    pc_load = 1'b1;
    pc_value = v;
    in_valid = 1'b1;
    #1;
    check("pcload_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    pc_load = 1'b0;
    in_valid = 1'b0;
    m_pc = v;
  endtask

  task automatic send(input logic [4:0] o, input logic ib, input logic [3:0] d,
                      input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] md,
                      input logic [31:0] imm, input logic [31:0] tgt,
                      input int stall, input bit abort);
    logic [31:0] ew, ea, xw;
    logic [1:0]  ec;
    model_encode(o, ib, d, s1, s2, md, imm, tgt, m_pc, ew, ec);
    @(negedge clk);
    op = o; ibit = ib; rd = d; rs1 = s1; rs2 = s2; modifier = md;
    imm_value = imm; target = tgt; in_valid = 1'b1;
    for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    op = $urandom; imm_value = $urandom; target = $urandom;
    check("enc_in_ready", {31'd0, in_ready}, 32'd0);
    check("enc_no_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    if (ec != 2'd0) begin
      check("err_valid", {31'd0, err_valid}, 32'd1);
      check("err_code", {30'd0, err_code}, {30'd0, ec});
      check("err_no_we", {31'd0, mem_we}, 32'd0);
      m_last_err = ec;
      @(negedge clk);
      check("err_pulse_end", {31'd0, err_valid}, 32'd0);
      check("err_code_hold", {30'd0, err_code}, {30'd0, ec});
      return;
    end
    exp_q.push_back(ew);
    addr_q.push_back(m_pc);
    xw = exp_q.pop_front();
    ea = addr_q.pop_front();
    check("we_latency", {31'd0, mem_we}, 32'd1);
    check("wr_addr", mem_addr, ea);
    check("wr_data", mem_wdata, xw);
    check("wr_no_err", {31'd0, err_valid}, 32'd0);
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      check("abort_in_ready", {31'd0, in_ready}, 32'd0);
      check("abort_mem_we", {31'd0, mem_we}, 32'd0);
      check("abort_words", {16'd0, words_written}, 32'd0);
      check("abort_addr", mem_addr, 32'd0);
      rst = 1'b0;
      m_pc = BASE;
      m_words = 16'd0;
      m_last_err = 2'd0;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      check("stall_we", {31'd0, mem_we}, 32'd1);
      check("stall_addr", mem_addr, ea);
      check("stall_data", mem_wdata, xw);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    m_pc = m_pc + 32'd1;
    m_words = m_words + 16'd1;
    check("done_we", {31'd0, mem_we}, 32'd0);
    check("done_words", {16'd0, words_written}, {16'd0, m_words});
    check("done_err_code", {30'd0, err_code}, {30'd0, m_last_err});
  endtask

  // Stimulus
  logic [4:0] op_list[8] = '{5'b00000, 5'b01001, 5'b01101, 5'b10000,
                             5'b10001, 5'b10010, 5'b10011, 5'b10100};

  initial begin
    logic [4:0]  r_op;
    logic [1:0]  r_md;
    logic [31:0] r_imm, r_tgt;
    logic [15:0] h;
    in_valid = 0; op = 0; ibit = 0; rd = 0; rs1 = 0; rs2 = 0; modifier = 0;
    imm_value = 0; target = 0; pc_load = 0; pc_value = 0; mem_ready = 0;
    do_reset();

    // add r1, r2, #-5 at pc 0
    send(5'b00000, 1, 4'd1, 4'd2, 4'd0, 2'b00, 32'hFFFF_FFFB, 32'h0, 0, 0);
    // mov r3, high immediate
    send(5'b01001, 1, 4'd3, 4'd0, 4'd0, 2'b10, 32'h1234_0000, 32'h0, 0, 0);
    // backward branch from 0x10 to 0x8
    load_pc(32'h10);
    send(5'b10010, 0, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0, 32'h8, 0, 0);
    // immediate out of range, then illegal modifier; pc must not move
    send(5'b00000, 1, 4'd1, 4'd1, 4'd0, 2'b00, 32'h0000_8000, 32'h0, 0, 0);
    send(5'b00000, 1, 4'd1, 4'd1, 4'd0, 2'b11, 32'h0000_0001, 32'h0, 0, 0);
    // register form with 3-cycle memory stall
    send(5'b00000, 0, 4'd5, 4'd6, 4'd7, 2'b00, 32'h0, 32'h0, 3, 0);
    // branch out of range, then boundary offsets
    send(5'b10011, 0, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0, m_pc + 32'h0400_0000, 0, 0);
    send(5'b10000, 0, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0, m_pc + 32'h03FF_FFFF, 0, 0);
    send(5'b10001, 0, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0, m_pc - 32'h0400_0000, 1, 0);
    send(5'b10100, 1, 4'hF, 4'hF, 4'hF, 2'b11, 32'hFFFF_FFFF, 32'h0, 0, 0);
    // reset during a write, then next write lands at BASE
    send(5'b01101, 0, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0, 32'h0, 0, 1);
    send(5'b00000, 1, 4'd2, 4'd3, 4'd0, 2'b01, 32'h0000_FFFF, 32'h0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) load_pc($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFE : $urandom);
      r_op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : op_list[$urandom_range(0, 7)];
      r_md = 2'($urandom_range(0, 3));
      h = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r_imm = $urandom;
        1: r_imm = {{16{h[15]}}, h};
        2: r_imm = {16'h0, h};
        default: r_imm = {h, 16'h0};
      endcase
      r_tgt = ($urandom_range(0, 2) == 0) ? $urandom
                                          : m_pc + {{6{h[15]}}, h, 10'($urandom)};
      send(r_op, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), r_md,
           r_imm, r_tgt, $urandom_range(0, 3), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
